// File: rtl/pipeline_stall_controller_pkg.sv
// Shared state encodings, default parameters and control-word constants for the stall controller.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    localparam int unsigned DEF_CNT_W        = 32;
    localparam int unsigned DEF_DRAIN_CYCLES = 4;
    localparam int unsigned DEF_MEM_TIMEOUT  = 64;

    // One pipeline control word: enables and bubble selects driven to the stage registers.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

    // Free-running pipeline.
    localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    // Data-memory freeze: everything holds, MEM/WB receives a NOP.
    localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // Front-end stall: PC and IF/ID hold, ID/EX gets a bubble, back end keeps moving.
    localparam pipe_ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    // Reset / halted: nothing written, both bubble muxes select NOP.
    localparam pipe_ctrl_t CTRL_IDLE   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard/memory/halt requests in, pipeline-register enables and status out.
interface pipeline_stall_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic             load_use_stall;
    logic             dmem_req;
    logic             dmem_ready;
    logic             halt_req;
    logic             pc_write;
    logic             IF_ID_write;
    logic             ID_EX_bubble;
    logic             EX_MEM_write;
    logic             MEM_WB_bubble;
    logic             halted;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side: raises requests, consumes the control word.
    modport master (
        output load_use_stall, dmem_req, dmem_ready, halt_req,
        input  pc_write, IF_ID_write, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble,
        input  halted, mem_error, stall_count
    );

    // Controller side.
    modport slave (
        input  load_use_stall, dmem_req, dmem_ready, halt_req,
        output pc_write, IF_ID_write, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble,
        output halted, mem_error, stall_count
    );
endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module pipeline_stall_controller_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Increment when enabled, sticking at all-ones.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/freeze arbiter with halt drain, memory-wait timeout and stall-cycle counter.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int unsigned MEM_TIMEOUT  = DEF_MEM_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    pipeline_stall_controller_if.slave    bus
);

    localparam int unsigned DRAIN_W = cnt_width(DRAIN_CYCLES - 1);
    localparam int unsigned WAIT_W  = cnt_width(MEM_TIMEOUT - 1);

    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

    state_e             state_q,     state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic               halted_q,    halted_d;
    logic               mem_error_q, mem_error_d;

    pipe_ctrl_t         ctrl_c;
    logic               mem_freeze_c;
    logic               stall_en_c;
    logic [CNT_W-1:0]   stall_count_c;

    assign mem_freeze_c = bus.dmem_req && !bus.dmem_ready;

    // State register; reset discards any drain or wait in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            wait_cnt_q  <= '0;
            halted_q    <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            halted_q    <= halted_d;
            mem_error_q <= mem_error_d;
        end
    end

    // Next-state: memory wait outranks halt; load-use stalls never leave RUN.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        halted_d    = halted_q;
        mem_error_d = mem_error_q;
        case (state_q)
            ST_RUN: begin
                if (mem_freeze_c) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else if (bus.halt_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = ST_HALTED;
                    mem_error_d = 1'b1;
                    halted_d    = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_DRAIN: begin
                // A memory freeze stalls the drain without consuming a cycle of it.
                if (!mem_freeze_c) begin
                    if (drain_cnt_q == '0) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Same-cycle control word from current state and requests.
    always_comb begin
        ctrl_c = CTRL_RUN;
        if (!reset) begin
            ctrl_c = CTRL_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_freeze_c) begin
                        ctrl_c = CTRL_FREEZE;
                    end else if (bus.halt_req || bus.load_use_stall) begin
                        ctrl_c = CTRL_BUBBLE;
                    end
                end
                ST_MEM_WAIT: ctrl_c = CTRL_FREEZE;
                ST_DRAIN:    ctrl_c = mem_freeze_c ? CTRL_FREEZE : CTRL_BUBBLE;
                ST_HALTED:   ctrl_c = CTRL_IDLE;
                default:     ctrl_c = CTRL_IDLE;
            endcase
        end
    end

    // Count every stalled cycle except while halted or in reset.
    assign stall_en_c = reset && !ctrl_c.pc_write && (state_q != ST_HALTED);

    pipeline_stall_controller_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .clr_n (reset),
        .en    (stall_en_c),
        .count (stall_count_c)
    );

    assign bus.pc_write      = ctrl_c.pc_write;
    assign bus.IF_ID_write   = ctrl_c.if_id_write;
    assign bus.ID_EX_bubble  = ctrl_c.id_ex_bubble;
    assign bus.EX_MEM_write  = ctrl_c.ex_mem_write;
    assign bus.MEM_WB_bubble = ctrl_c.mem_wb_bubble;
    assign bus.halted        = halted_q;
    assign bus.mem_error     = mem_error_q;
    assign bus.stall_count   = stall_count_c;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: a default instance plus a 4-bit-counter instance sharing the same stimulus.
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipeline_stall_controller_if #(.CNT_W(32)) bus  ();
    pipeline_stall_controller_if #(.CNT_W(4))  bus4 ();

    pipeline_stall_controller #(
        .CNT_W(32), .DRAIN_CYCLES(4), .MEM_TIMEOUT(64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pipeline_stall_controller #(
        .CNT_W(4), .DRAIN_CYCLES(4), .MEM_TIMEOUT(64)
    ) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // {pc_write, IF_ID_write, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble}
    localparam logic [4:0] O_RUN  = 5'b11010;
    localparam logic [4:0] O_FRZ  = 5'b00001;
    localparam logic [4:0] O_BUB  = 5'b00110;
    localparam logic [4:0] O_IDLE = 5'b00101;

    logic [4:0] outs;
    assign outs = {bus.pc_write, bus.IF_ID_write, bus.ID_EX_bubble, bus.EX_MEM_write, bus.MEM_WB_bubble};

    int n_checks;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic [4:0] exp);
        chk({tag, "_outs"}, 32'(outs), 32'(exp));
    endtask

    task automatic chk_sc(input string tag, input int exp);
        chk({tag, "_cnt"}, bus.stall_count, 32'(exp));
    endtask

    task automatic chk_sc4(input string tag, input int exp);
        chk({tag, "_cnt4"}, 32'(bus4.stall_count), 32'(exp));
    endtask

    task automatic chk_flags(input string tag, input logic exp_halted, input logic exp_err);
        chk({tag, "_halted"}, 32'(bus.halted), 32'(exp_halted));
        chk({tag, "_memerr"}, 32'(bus.mem_error), 32'(exp_err));
    endtask

    // Drive one cycle of inputs on the falling edge and let the Mealy outputs settle.
    task automatic step(input logic rst, input logic lu, input logic dreq,
                        input logic rdy, input logic halt);
        @(negedge clk);
        reset               = rst;
        bus.load_use_stall  = lu;
        bus.dmem_req        = dreq;
        bus.dmem_ready      = rdy;
        bus.halt_req        = halt;
        bus4.load_use_stall = lu;
        bus4.dmem_req       = dreq;
        bus4.dmem_ready     = rdy;
        bus4.halt_req       = halt;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.load_use_stall  = 1'b0; bus.dmem_req  = 1'b0; bus.dmem_ready  = 1'b0; bus.halt_req  = 1'b0;
        bus4.load_use_stall = 1'b0; bus4.dmem_req = 1'b0; bus4.dmem_ready = 1'b0; bus4.halt_req = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk_o("reset", O_IDLE);
        end
        chk_flags("reset", 1'b0, 1'b0);
        chk_sc("reset", 0);

        // Release: RUN baseline
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("run0", O_RUN);
        chk_sc("run0", 0);

        // Single load-use bubble
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_o("lu1", O_BUB);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("lu1_after", O_RUN);
        chk_sc("lu1_after", 1);

        // Back-to-back load-use bubbles
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_o("lu2a", O_BUB);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_o("lu2b", O_BUB);
        chk_sc("lu2b", 2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("lu2_after", O_RUN);
        chk_sc("lu2_after", 3);

        // Memory wait: three not-ready cycles then ready; load-use inside is ignored
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_o("mw1", O_FRZ);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_o("mw2_lu", O_FRZ);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_o("mw3", O_FRZ);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_o("mw_ready", O_FRZ);
        chk_sc("mw_ready", 6);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("mw_after", O_RUN);
        chk_sc("mw_after", 7);

        // Halt pulse followed by a four-cycle drain
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_o("halt_req", O_BUB);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk_o("drain", O_BUB);
            chk_flags("drain", 1'b0, 1'b0);
            chk_sc("drain", 8 + i);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_o("halted", O_IDLE);
        chk_flags("halted", 1'b1, 1'b0);
        chk_sc("halted", 12);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_o("halted_hold", O_IDLE);
        chk_sc("halted_hold", 12);
        chk_sc4("halted_hold", 12);

        // Reset out of HALTED
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("rst2", O_IDLE);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("rst2_run", O_RUN);
        chk_flags("rst2_run", 1'b0, 1'b0);
        chk_sc("rst2_run", 0);

        // Drain stretched by one memory freeze
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_o("dfz_req", O_BUB);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("dfz_d3", O_BUB);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_o("dfz_freeze", O_FRZ);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("dfz_d2", O_BUB);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("dfz_d1", O_BUB);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("dfz_d0", O_BUB);
        chk_flags("dfz_d0", 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("dfz_halted", O_IDLE);
        chk_flags("dfz_halted", 1'b1, 1'b0);
        chk_sc("dfz_halted", 6);

        // Reset asserted mid-drain: no partial drain resumes
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_o("mid_req", O_BUB);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("mid_drain", O_BUB);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("mid_rst", O_IDLE);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("mid_run", O_RUN);
        chk_sc("mid_run", 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("mid_still_run", O_RUN);
        chk_flags("mid_still_run", 1'b0, 1'b0);

        // Twenty load-use stalls: 32-bit counter tracks, 4-bit counter pins at 15
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            chk_sc("sat", i - 1);
            chk_sc4("sat", (i - 1 > 15) ? 15 : i - 1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_sc("sat_end", 20);
        chk_sc4("sat_end", 15);

        // Memory-wait timeout; first cycle also carries halt and load-use (memory wins)
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk_o("to_first", O_FRZ);
        for (int i = 2; i <= 64; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            chk_o("to_wait", O_FRZ);
            chk_flags("to_wait", 1'b0, 1'b0);
        end
        chk_sc("to_wait64", 63);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_o("to_halted", O_IDLE);
        chk_flags("to_halted", 1'b1, 1'b1);
        chk_sc("to_halted", 64);
        chk_sc4("to_halted", 15);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("to_rst", O_IDLE);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_o("to_clear", O_RUN);
        chk_flags("to_clear", 1'b0, 1'b0);
        chk_sc("to_clear", 0);
        chk_sc4("to_clear", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
